spatz_vrf_banked: RTL and testbench
===================================

// Module: spatz_vrf_banked
// PURPOSE
// Parametrised banked vector register file for the Spatz VPU, between the controller/VFU/VLSU/slide unit and storage.
// Interleaves NR_BANKS flop-based banks on element-index bits; each bank has one write port and NR_BANK_RPORTS read slots.
// Arbitration is per-bank round-robin (fairness, no starvation). Read data is registered: one-cycle latency with explicit grant/valid.
// PARAMETERS
// NR_READ_PORTS   5                      client read ports
// NR_WRITE_PORTS  3                      client write ports
// NR_BANKS        4                      banks; power of two, >=2
// NR_BANK_RPORTS  3                      read slots per bank; read port p uses slot p % NR_BANK_RPORTS
// NR_VREG         spatz_pkg::NRVREG      architectural vector registers
// VLEN            spatz_pkg::VLEN        register width [bit]
// ELEM_WIDTH      N_IPU*ELEN             bank word width [bit]; VLEN % (NR_BANKS*ELEM_WIDTH) == 0
// PORTS
// clk_i      in   1                         clock
// rst_ni     in   1                         async reset, active low
// waddr_i    in   NR_WRITE_PORTS x AW       {vreg, bank, elem}; AW = log2(NR_VREG)+log2(VLEN/ELEM_WIDTH)
// wdata_i    in   NR_WRITE_PORTS x ELEM_WIDTH write data
// wbe_i      in   NR_WRITE_PORTS x ELEM_WIDTH/8 byte enables
// we_i       in   NR_WRITE_PORTS            write request
// wgnt_o     out  NR_WRITE_PORTS            write accepted this cycle (comb)
// raddr_i    in   NR_READ_PORTS x AW        read address
// re_i       in   NR_READ_PORTS             read request
// rgnt_o     out  NR_READ_PORTS             read accepted this cycle (comb)
// rdata_o    out  NR_READ_PORTS x ELEM_WIDTH read data, registered
// rvalid_o   out  NR_READ_PORTS             rdata_o valid; high exactly one cycle after rgnt_o
// BEHAVIOUR
// - Decode: EPB = VLEN/(NR_BANKS*ELEM_WIDTH). addr[log2 EPB-1:0] = elem in bank; next log2 NR_BANKS bits = bank; MSBs = vreg.
//   Bank row = {vreg, elem}. EPB==1 leaves elem field empty.
// - Write arb: per bank, round-robin among ports with we_i and matching bank. One winner per bank per cycle.
//   wgnt_o[p]=1 iff winner. Pointer moves to winner+1 (mod NR_WRITE_PORTS) on grant; else holds.
//   Losers keep we_i/addr/data stable and retry; the block holds no write state for them.
// - Write commit: granted bytes (wbe_i=1) update on the rising edge closing the grant cycle; others unchanged. wbe_i==0 with grant: legal no-op, still granted.
// - Read arb: per (bank,slot), round-robin among read ports mapped to that slot with re_i and matching bank.
//   Pointer per (bank,slot), same update rule as writes. Ports on different slots never conflict.
// - Read pipeline: grant in cycle T -> rvalid_o=1, rdata_o=row contents at start of T, in cycle T+1.
//   No write bypass: a same-cycle write to the same row is not visible (read-before-write); visible from T+1 grants.
//   Ungranted port: rvalid_o=0 next cycle, rdata_o holds last value. Back-to-back grants give full throughput.
// - Simultaneous: write and reads to one bank in one cycle all proceed; ports on distinct banks never stall each other.
// - Reset (async, any time): storage=0, all RR pointers=0, rvalid_o=0, rdata_o=0. In-flight reads dropped (no rvalid).
//   wgnt_o/rgnt_o are comb and 0 while rst_ni=0.
// - Elaboration $error: NR_BANKS not power of two; EPB==0; NR_WRITE_PORTS>NR_BANKS*1 is legal (arbitrated), NR_*_PORTS<1 is not.
// STRUCTURE
// - spatz_pkg: vreg_addr_t, vreg_data_t, vreg_be_t; add vrf_bank_addr_t and constant VRF_ELEM_PER_BANK.
// - Sub-module spatz_vrf_bank: async-reset flop array NR_VREG*EPB x ELEM_WIDTH, 1 byte-enabled write port,
//   NR_BANK_RPORTS comb read ports. Instantiated NR_BANKS times.
// - Top level owns decode, RR pointers (plain registers, no common_cells arbiter) and the rdata/rvalid output stage.
// TESTING  (cfg: VLEN=1024, ELEM_WIDTH=128, NR_BANKS=4 -> EPB=2, AW=8, addr={vreg[7:3],bank[2:1],elem[0]})
// 1 Write port0 addr 0x0B (v1,bank1,elem1) data 0xA5.., wbe all ones; next cycle read port0 0x0B -> rgnt_o[0]=1, then rvalid_o[0]=1, rdata_o[0]=0xA5...
// 2 Ports 0,1,2 write bank1 for 3 cycles -> wgnt_o one-hot sequence 001,010,100; next idle-pointer request from port0 granted.
// 3 Read ports 0,3 (slot 0) both bank2 held 2 cycles -> rgnt_o[0] then rgnt_o[3]; port1 (slot1) on bank2 granted both cycles.
// 4 Same cycle write 0x11 and read of row 0x04 (old 0x22) -> rdata_o=0x22 at T+1; read at T+1 -> 0x11 at T+2.
// 5 wbe_i=0x000F on 0x..FF row written with zeros -> only bytes 3:0 zero, rest 0xFF.
// 6 Assert rst_ni=0 in cycle after read grant -> rvalid_o=0 immediately; post-reset reads of written rows return 0.

Source files
------------

// File: rtl/spatz_vrf_banked_pkg.sv
// Shared constants and types for the banked Spatz vector register file.
// Defaults describe a 32 x 1024-bit VRF built from 128-bit bank words.
package spatz_vrf_banked_pkg;

  localparam int unsigned NRVREG = 32;
  localparam int unsigned VLEN   = 1024;
  localparam int unsigned N_IPU  = 2;
  localparam int unsigned ELEN   = 64;
  localparam int unsigned ELEMW  = N_IPU * ELEN;
  localparam int unsigned NRBANK = 4;

  localparam int unsigned VRF_ELEM_PER_BANK =
    VLEN / (NRBANK * ELEMW);

  localparam int unsigned VRF_AW =
    $clog2(NRVREG) + $clog2(VLEN / ELEMW);

  localparam int unsigned VRF_ROW_W =
    $clog2(NRVREG * VRF_ELEM_PER_BANK);

  typedef logic [VRF_AW-1:0]    vreg_addr_t;
  typedef logic [ELEMW-1:0]     vreg_data_t;
  typedef logic [ELEMW/8-1:0]   vreg_be_t;
  typedef logic [VRF_ROW_W-1:0] vrf_bank_addr_t;

endpackage

// File: rtl/spatz_vrf_bank.sv
// One VRF bank: flop array with a byte-enabled write port
// and several combinational read ports.
module spatz_vrf_bank #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ELEM_WIDTH = 128,
  parameter int unsigned NR_RPORTS  = 3,
  parameter int unsigned AW         = 6,
  localparam int unsigned BEW       = ELEM_WIDTH / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  we_i,
  input  logic [AW-1:0]                         waddr_i,
  input  logic [ELEM_WIDTH-1:0]                 wdata_i,
  input  logic [BEW-1:0]                        wbe_i,
  input  logic [NR_RPORTS-1:0][AW-1:0]          raddr_i,
  output logic [NR_RPORTS-1:0][ELEM_WIDTH-1:0]  rdata_o
);

  import spatz_vrf_banked_pkg::*;

  logic [DEPTH-1:0][ELEM_WIDTH-1:0] mem_q, mem_d;

  // Merge the enabled bytes of the write into the addressed row
  always_comb begin : p_wr
    mem_d = mem_q;
    if (we_i) begin
      for (int unsigned i = 0; i < BEW; i++) begin
        if (wbe_i[i]) begin
          mem_d[waddr_i][i*8 +: 8] = wdata_i[i*8 +: 8];
        end
      end
    end
  end

  // Storage, cleared on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_mem
    if (!rst_ni) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports see the row contents before this cycle's write
  always_comb begin : p_rd
    rdata_o = '0;
    for (int unsigned s = 0; s < NR_RPORTS; s++) begin
      rdata_o[s] = mem_q[raddr_i[s]];
    end
  end

endmodule

// File: rtl/spatz_vrf_banked.sv
// Banked VRF: element-interleaved banks with per-bank
// round-robin write arbitration and per-slot read arbitration.
module spatz_vrf_banked #(
  parameter int unsigned NR_READ_PORTS  = 5,
  parameter int unsigned NR_WRITE_PORTS = 3,
  parameter int unsigned NR_BANKS       = 4,
  parameter int unsigned NR_BANK_RPORTS = 3,
  parameter int unsigned NR_VREG        =
    spatz_vrf_banked_pkg::NRVREG,
  parameter int unsigned VLEN           =
    spatz_vrf_banked_pkg::VLEN,
  parameter int unsigned ELEM_WIDTH     =
    spatz_vrf_banked_pkg::ELEMW,
  localparam int unsigned EPB =
    VLEN / (NR_BANKS * ELEM_WIDTH),
  localparam int unsigned AW  =
    $clog2(NR_VREG) + $clog2(VLEN / ELEM_WIDTH),
  localparam int unsigned BEW = ELEM_WIDTH / 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NR_WRITE_PORTS-1:0][AW-1:0]         waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][ELEM_WIDTH-1:0] wdata_i,
  input  logic [NR_WRITE_PORTS-1:0][BEW-1:0]        wbe_i,
  input  logic [NR_WRITE_PORTS-1:0]                 we_i,
  output logic [NR_WRITE_PORTS-1:0]                 wgnt_o,
  input  logic [NR_READ_PORTS-1:0][AW-1:0]          raddr_i,
  input  logic [NR_READ_PORTS-1:0]                  re_i,
  output logic [NR_READ_PORTS-1:0]                  rgnt_o,
  output logic [NR_READ_PORTS-1:0][ELEM_WIDTH-1:0]  rdata_o,
  output logic [NR_READ_PORTS-1:0]                  rvalid_o
);

  import spatz_vrf_banked_pkg::*;

  localparam int unsigned EW  = $clog2(EPB);
  localparam int unsigned BW  = $clog2(NR_BANKS);
  localparam int unsigned RWR = $clog2(NR_VREG * EPB);
  localparam int unsigned RW  = (RWR > 0) ? RWR : 1;
  localparam int unsigned NRS = NR_BANK_RPORTS;
  localparam int unsigned WPW =
    (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1;
  localparam int unsigned RPW =
    (NR_READ_PORTS > 1) ? $clog2(NR_READ_PORTS) : 1;

  if (NR_BANKS < 2 || (NR_BANKS & (NR_BANKS - 1)) != 0)
  begin : g_err_banks
    $error("NR_BANKS must be a power of two >= 2");
  end
  if (EPB == 0) begin : g_err_epb
    $error("VLEN too small for NR_BANKS*ELEM_WIDTH");
  end
  if (NR_READ_PORTS < 1 || NR_WRITE_PORTS < 1)
  begin : g_err_ports
    $error("need at least one read and one write port");
  end

  function automatic int unsigned bank_of(
    input logic [AW-1:0] a
  );
    return (32'(a) >> EW) % NR_BANKS;
  endfunction

  function automatic logic [RW-1:0] row_of(
    input logic [AW-1:0] a
  );
    int unsigned x;
    x = 32'(a);
    return RW'((x >> (EW + BW)) * EPB + x % EPB);
  endfunction

  logic [NR_BANKS-1:0]                          bank_we;
  logic [NR_BANKS-1:0][RW-1:0]                  bank_waddr;
  logic [NR_BANKS-1:0][ELEM_WIDTH-1:0]          bank_wdata;
  logic [NR_BANKS-1:0][BEW-1:0]                 bank_wbe;
  logic [NR_BANKS-1:0][NRS-1:0][RW-1:0]         bank_raddr;
  logic [NR_BANKS-1:0][NRS-1:0][ELEM_WIDTH-1:0] bank_rdata;

  logic [NR_BANKS-1:0][WPW-1:0]          wptr_q, wptr_d;
  logic [NR_BANKS-1:0][NRS-1:0][RPW-1:0] rptr_q, rptr_d;
  logic [NR_READ_PORTS-1:0][ELEM_WIDTH-1:0] rdata_q, rdata_d;
  logic [NR_READ_PORTS-1:0]                 rvalid_q, rvalid_d;

  // Per-bank write round-robin: lowest rank from pointer wins
  always_comb begin : p_warb
    int unsigned best;
    int unsigned rank;
    wgnt_o     = '0;
    wptr_d     = wptr_q;
    bank_we    = '0;
    bank_waddr = '0;
    bank_wdata = '0;
    bank_wbe   = '0;
    best       = 0;
    rank       = 0;
    for (int unsigned b = 0; b < NR_BANKS; b++) begin
      best = NR_WRITE_PORTS;
      for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
        rank = (p + NR_WRITE_PORTS - 32'(wptr_q[b]))
               % NR_WRITE_PORTS;
        if (rst_ni && we_i[p] &&
            bank_of(waddr_i[p]) == b && rank < best) begin
          best = rank;
        end
      end
      for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
        rank = (p + NR_WRITE_PORTS - 32'(wptr_q[b]))
               % NR_WRITE_PORTS;
        if (rst_ni && we_i[p] &&
            bank_of(waddr_i[p]) == b && rank == best) begin
          wgnt_o[p]     = 1'b1;
          wptr_d[b]     = WPW'((p + 1) % NR_WRITE_PORTS);
          bank_we[b]    = 1'b1;
          bank_waddr[b] = row_of(waddr_i[p]);
          bank_wdata[b] = wdata_i[p];
          bank_wbe[b]   = wbe_i[p];
        end
      end
    end
  end

  // Per-(bank,slot) read round-robin over ports on that slot
  always_comb begin : p_rarb
    int unsigned best;
    int unsigned rank;
    rgnt_o     = '0;
    rptr_d     = rptr_q;
    bank_raddr = '0;
    best       = 0;
    rank       = 0;
    for (int unsigned b = 0; b < NR_BANKS; b++) begin
      for (int unsigned s = 0; s < NRS; s++) begin
        best = NR_READ_PORTS;
        for (int unsigned p = 0; p < NR_READ_PORTS; p++) begin
          rank = (p + NR_READ_PORTS - 32'(rptr_q[b][s]))
                 % NR_READ_PORTS;
          if (p % NRS == s && rst_ni && re_i[p] &&
              bank_of(raddr_i[p]) == b && rank < best) begin
            best = rank;
          end
        end
        for (int unsigned p = 0; p < NR_READ_PORTS; p++) begin
          rank = (p + NR_READ_PORTS - 32'(rptr_q[b][s]))
                 % NR_READ_PORTS;
          if (p % NRS == s && rst_ni && re_i[p] &&
              bank_of(raddr_i[p]) == b && rank == best) begin
            rgnt_o[p]        = 1'b1;
            rptr_d[b][s]     = RPW'((p + 1) % NR_READ_PORTS);
            bank_raddr[b][s] = row_of(raddr_i[p]);
          end
        end
      end
    end
  end

  // Capture granted read data; ungranted ports hold their value
  always_comb begin : p_rout
    rdata_d  = rdata_q;
    rvalid_d = rgnt_o;
    for (int unsigned p = 0; p < NR_READ_PORTS; p++) begin
      for (int unsigned b = 0; b < NR_BANKS; b++) begin
        if (rgnt_o[p] && bank_of(raddr_i[p]) == b) begin
          rdata_d[p] = bank_rdata[b][p % NRS];
        end
      end
    end
  end

  // Arbiter pointers and the registered read output stage
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_regs
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

  for (genvar b = 0; b < NR_BANKS; b++) begin : g_bank
    spatz_vrf_bank #(
      .DEPTH      (NR_VREG * EPB),
      .ELEM_WIDTH (ELEM_WIDTH),
      .NR_RPORTS  (NRS),
      .AW         (RW)
    ) i_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (bank_we[b]),
      .waddr_i (bank_waddr[b]),
      .wdata_i (bank_wdata[b]),
      .wbe_i   (bank_wbe[b]),
      .raddr_i (bank_raddr[b]),
      .rdata_o (bank_rdata[b])
    );
  end

endmodule

// File: tb/tb_spatz_vrf_banked.sv
// Bench for spatz_vrf_banked: directed scenarios plus random
// traffic against an address-keyed reference model.
module tb_spatz_vrf_banked;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0][7:0]   waddr;
  logic [2:0][127:0] wdata;
  logic [2:0][15:0]  wbe;
  logic [2:0]        we;
  logic [2:0]        wgnt;
  logic [4:0][7:0]   raddr;
  logic [4:0]        re;
  logic [4:0]        rgnt;
  logic [4:0][127:0] rdata;
  logic [4:0]        rvalid;

  int total = 0;
  int bad   = 0;

  logic [127:0]      m_mem [256];
  int                wptr_m [4];
  int                rptr_m [4][3];
  logic [4:0][127:0] exp_rdata;
  logic [4:0]        exp_rvalid;
  logic [2:0]        last_wgnt;
  logic [4:0]        last_rgnt;

  always #5 clk = ~clk;

  spatz_vrf_banked dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .wbe_i    (wbe),
    .we_i     (we),
    .wgnt_o   (wgnt),
    .raddr_i  (raddr),
    .re_i     (re),
    .rgnt_o   (rgnt),
    .rdata_o  (rdata),
    .rvalid_o (rvalid)
  );

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // addr = {vreg[7:3], bank[2:1], elem[0]}
  function automatic int bank_of(logic [7:0] a);
    return int'(a[2:1]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    for (int b = 0; b < 4; b++) begin
      wptr_m[b] = 0;
      for (int s = 0; s < 3; s++) rptr_m[b][s] = 0;
    end
    exp_rdata  = '0;
    exp_rvalid = '0;
  endtask

  task automatic idle();
    we    = '0;
    re    = '0;
    waddr = '0;
    raddr = '0;
    wdata = '0;
    wbe   = '0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Call right after driving inputs following a falling edge
  task automatic run_cycle();
    logic [2:0] eg;
    logic [4:0] er;
    int p;
    bit found;
    #1;
    eg = '0;
    er = '0;
    for (int b = 0; b < 4; b++) begin
      found = 0;
      for (int k = 0; k < 3; k++) begin
        p = (wptr_m[b] + k) % 3;
        if (!found && we[p] && bank_of(waddr[p]) == b) begin
          found = 1;
          eg[p] = 1'b1;
          wptr_m[b] = (p + 1) % 3;
        end
      end
      for (int s = 0; s < 3; s++) begin
        found = 0;
        for (int k = 0; k < 5; k++) begin
          p = (rptr_m[b][s] + k) % 5;
          if (!found && p % 3 == s && re[p] &&
              bank_of(raddr[p]) == b) begin
            found = 1;
            er[p] = 1'b1;
            rptr_m[b][s] = (p + 1) % 5;
          end
        end
      end
    end
    check("wgnt", 128'(wgnt), 128'(eg));
    check("rgnt", 128'(rgnt), 128'(er));
    last_wgnt = wgnt;
    last_rgnt = rgnt;
    for (int i = 0; i < 5; i++)
      if (er[i]) exp_rdata[i] = m_mem[raddr[i]];
    for (int i = 0; i < 3; i++)
      if (eg[i])
        for (int j = 0; j < 16; j++)
          if (wbe[i][j])
            m_mem[waddr[i]][j*8 +: 8] = wdata[i][j*8 +: 8];
    exp_rvalid = er;
    @(posedge clk);
    #1;
    check("rvalid", 128'(rvalid), 128'(exp_rvalid));
    for (int i = 0; i < 5; i++)
      check($sformatf("rdata%0d", i), rdata[i], exp_rdata[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    we = 3'b111;
    re = 5'b11111;
    #12;
    check("rst_wgnt", 128'(wgnt), 128'(0));
    check("rst_rgnt", 128'(rgnt), 128'(0));
    check("rst_rvalid", 128'(rvalid), 128'(0));
    check("rst_rdata0", rdata[0], 128'(0));
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Three writers on bank1: one grant per cycle, rotating
    @(negedge clk);
    idle();
    we       = 3'b111;
    waddr[0] = 8'h0A;
    waddr[1] = 8'h02;
    waddr[2] = 8'h1A;
    wdata[0] = rnd128();
    wdata[1] = rnd128();
    wdata[2] = rnd128();
    wbe      = '1;
    run_cycle();
    check("t2_g0", 128'(last_wgnt), 128'(3'b001));
    @(negedge clk);
    run_cycle();
    check("t2_g1", 128'(last_wgnt), 128'(3'b010));
    @(negedge clk);
    run_cycle();
    check("t2_g2", 128'(last_wgnt), 128'(3'b100));
    @(negedge clk);
    we = 3'b011;
    run_cycle();
    check("t2_g3", 128'(last_wgnt), 128'(3'b001));

    // Ports 0 and 3 share slot 0 on bank2; port 1 has its own slot
    @(negedge clk);
    idle();
    re       = 5'b01011;
    raddr[0] = 8'h14;
    raddr[1] = 8'h14;
    raddr[3] = 8'h15;
    run_cycle();
    check("t3_r0", 128'(last_rgnt), 128'(5'b00011));
    @(negedge clk);
    run_cycle();
    check("t3_r1", 128'(last_rgnt), 128'(5'b01010));

    // Write then read back one row
    @(negedge clk);
    idle();
    we[0]    = 1'b1;
    waddr[0] = 8'h0B;
    wdata[0] = {16{8'hA5}};
    wbe[0]   = '1;
    run_cycle();
    @(negedge clk);
    idle();
    re[0]    = 1'b1;
    raddr[0] = 8'h0B;
    run_cycle();
    check("t1_rgnt", 128'(last_rgnt[0]), 128'(1));
    check("t1_rvalid", 128'(rvalid[0]), 128'(1));
    check("t1_rdata", rdata[0], {16{8'hA5}});

    // Read-before-write on the same row
    @(negedge clk);
    idle();
    we[0]    = 1'b1;
    waddr[0] = 8'h04;
    wdata[0] = 128'h22;
    wbe[0]   = '1;
    run_cycle();
    @(negedge clk);
    wdata[0] = 128'h11;
    re[0]    = 1'b1;
    raddr[0] = 8'h04;
    run_cycle();
    check("t4_old", rdata[0], 128'h22);
    @(negedge clk);
    idle();
    re[0]    = 1'b1;
    raddr[0] = 8'h04;
    run_cycle();
    check("t4_new", rdata[0], 128'h11);

    // Partial byte enables
    @(negedge clk);
    idle();
    we[1]    = 1'b1;
    waddr[1] = 8'h33;
    wdata[1] = '1;
    wbe[1]   = '1;
    run_cycle();
    @(negedge clk);
    wdata[1] = '0;
    wbe[1]   = 16'h000F;
    run_cycle();
    @(negedge clk);
    idle();
    re[2]    = 1'b1;
    raddr[2] = 8'h33;
    run_cycle();
    check("t5_be", rdata[2], {{96{1'b1}}, 32'h0});

    // Random traffic on a few registers to force conflicts
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we = 3'($urandom());
      re = 5'($urandom());
      for (int i = 0; i < 3; i++) begin
        waddr[i] = 8'($urandom_range(0, 31));
        wdata[i] = rnd128();
        wbe[i]   = 16'($urandom());
      end
      for (int i = 0; i < 5; i++)
        raddr[i] = 8'($urandom_range(0, 31));
      run_cycle();
    end

    // Reset right after a read grant drops the pending rvalid
    @(negedge clk);
    idle();
    re[0]    = 1'b1;
    raddr[0] = 8'h0B;
    run_cycle();
    rst_n = 1'b0;
    #1;
    check("t6_rvalid", 128'(rvalid[0]), 128'(0));
    check("t6_rdata", rdata[0], 128'(0));
    check("t6_rgnt", 128'(rgnt[0]), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    re[0]    = 1'b1;
    raddr[0] = 8'h0B;
    re[1]    = 1'b1;
    raddr[1] = 8'h04;
    run_cycle();
    check("t6_post0", rdata[0], 128'(0));
    check("t6_post1", rdata[1], 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
